// File: rtl/sum_accumulator.sv
// Batch accumulator for 4-bit adder results with valid/ready handshakes on both sides.
// Define SUM_ACCUMULATOR_SAT_EN to saturate acc_out on overflow; otherwise it wraps.
module sum_accumulator #(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [3:0]       sum_in,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [3:0]       count,
    output logic             ovf
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             xfer;
    logic [ACC_W:0]   sum_wide;
    logic [3:0]       cnt_inc;

    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);
    assign xfer      = in_valid && in_ready;
    // One extra bit catches the carry out of the accumulator.
    assign sum_wide  = {1'b0, acc_q} + {{(ACC_W-3){1'b0}}, sum_in};
    assign cnt_inc   = cnt_q + 4'd1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    if (xfer) begin
`ifdef SUM_ACCUMULATOR_SAT_EN
                        // Once saturated, stay pinned at full scale for the batch.
                        if (sum_wide[ACC_W] || ovf_q) begin
                            acc_d = '1;
                        end else begin
                            acc_d = sum_wide[ACC_W-1:0];
                        end
`else
                        acc_d = sum_wide[ACC_W-1:0];
`endif
                        ovf_d   = ovf_q | sum_wide[ACC_W];
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == 4'(N_SAMPLES)) ? DONE : ACCUM;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign acc_out = acc_q;
    assign count   = cnt_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: vector table, batch scoreboard, and
// side instances with ACC_W=6 and N_SAMPLES=1.
module tb_sum_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clear, in_valid, out_ready;
    logic [3:0] sum_in;
    logic       in_ready, out_valid, ovf;
    logic [7:0] acc_out;
    logic [3:0] count;

    logic       in_ready6, out_valid6, ovf6;
    logic [5:0] acc_out6;
    logic [3:0] count6;

    logic       in_valid1, out_ready1;
    logic [3:0] sum_in1;
    logic       in_ready1, out_valid1, ovf1;
    logic [7:0] acc_out1;
    logic [3:0] count1;

    sum_accumulator dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .sum_in(sum_in),
        .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .count(count), .ovf(ovf)
    );

    sum_accumulator #(.N_SAMPLES(8), .ACC_W(6)) dut6 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .sum_in(sum_in),
        .in_ready(in_ready6), .out_valid(out_valid6), .out_ready(out_ready),
        .acc_out(acc_out6), .count(count6), .ovf(ovf6)
    );

    sum_accumulator #(.N_SAMPLES(1), .ACC_W(8)) dut1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid1), .sum_in(sum_in1),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_ready(out_ready1),
        .acc_out(acc_out1), .count(count1), .ovf(ovf1)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit       r;
        bit       c;
        bit       v;
        bit [3:0] s;
        bit       ordy;
        int       acc;
        int       cnt;
        bit       ov;
        bit       ovld;
        bit       irdy;
    } vec_t;

    typedef struct {
        int acc;
        int cnt;
        bit ov;
    } res_t;

    vec_t tbl[13];
    res_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_result(input string name);
        int   n;
        res_t r;
        n = 0;
        while (!out_valid && n < 40) begin
            step();
            n++;
        end
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got empty scoreboard expected a queued result", name);
        end else begin
            r = sbq.pop_front();
            if (!out_valid) begin
                checks++;
                errors++;
                $display("FAIL %s: got out_valid=0 after 40 cycles expected 1", name);
            end else begin
                chk({name, ".acc"}, 32'(acc_out), 32'(r.acc));
                chk({name, ".cnt"}, 32'(count), 32'(r.cnt));
                chk({name, ".ovf"}, 32'(ovf), 32'(r.ov));
            end
        end
    endtask

    task automatic random_batch(input string name);
        int sent;
        int total;
        int gap;
        sent  = 0;
        total = 0;
        while (sent < 8) begin
            in_valid = 1'($urandom_range(0, 1));
            sum_in   = 4'($urandom_range(0, 15));
            if (in_valid) begin
                sent++;
                total += int'(sum_in);
                if (sent == 8) sbq.push_back('{total, 8, (total > 255)});
            end
            step();
        end
        in_valid = 1'b0;
        wait_result(name);
        gap = $urandom_range(0, 3);
        repeat (gap) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, ".drain_acc"}, 32'(acc_out), 32'd0);
        chk({name, ".drain_ovld"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int exp6;
`ifdef SUM_ACCUMULATOR_SAT_EN
        exp6 = 63;
`else
        exp6 = 56;
`endif
        //           r  c  v  s      ordy acc cnt ov ovld irdy
        tbl[0]  = '{0, 0, 1, 4'd2, 0,    2,  1,  0, 0,   1};
        tbl[1]  = '{0, 0, 0, 4'd2, 0,    2,  1,  0, 0,   1};
        tbl[2]  = '{0, 0, 0, 4'd9, 0,    2,  1,  0, 0,   1};
        tbl[3]  = '{0, 0, 1, 4'd2, 0,    4,  2,  0, 0,   1};
        tbl[4]  = '{0, 0, 0, 4'd2, 1,    4,  2,  0, 0,   1};
        tbl[5]  = '{0, 0, 1, 4'd2, 0,    6,  3,  0, 0,   1};
        tbl[6]  = '{0, 1, 1, 4'd5, 0,    0,  0,  0, 0,   1};
        tbl[7]  = '{0, 0, 1, 4'd5, 0,    5,  1,  0, 0,   1};
        tbl[8]  = '{0, 0, 1, 4'd6, 0,   11,  2,  0, 0,   1};
        tbl[9]  = '{0, 0, 1, 4'd7, 0,   18,  3,  0, 0,   1};
        tbl[10] = '{1, 0, 1, 4'd9, 0,    0,  0,  0, 0,   1};
        tbl[11] = '{0, 0, 1, 4'd3, 0,    3,  1,  0, 0,   1};
        tbl[12] = '{0, 1, 0, 4'd0, 0,    0,  0,  0, 0,   1};

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sum_in = 4'd0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; sum_in1 = 4'd0;
        step();
        step();
        chk("rst.acc", 32'(acc_out), 32'd0);
        chk("rst.cnt", 32'(count), 32'd0);
        chk("rst.ovf", 32'(ovf), 32'd0);
        chk("rst.ovld", 32'(out_valid), 32'd0);
        rst = 1'b0;
        chk("rst.irdy", 32'(in_ready), 32'd1);

        for (int i = 0; i < 13; i++) begin
            rst = tbl[i].r; clear = tbl[i].c; in_valid = tbl[i].v;
            sum_in = tbl[i].s; out_ready = tbl[i].ordy;
            step();
            chk($sformatf("vec%0d.acc", i), 32'(acc_out), 32'(tbl[i].acc));
            chk($sformatf("vec%0d.cnt", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("vec%0d.ovf", i), 32'(ovf), 32'(tbl[i].ov));
            chk($sformatf("vec%0d.ovld", i), 32'(out_valid), 32'(tbl[i].ovld));
            chk($sformatf("vec%0d.irdy", i), 32'(in_ready), 32'(tbl[i].irdy));
        end
        rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

        // Eight back-to-back 15s: 120 in 8 bits, overflow in 6 bits from the 5th sample.
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            sum_in   = 4'd15;
            if (k == 8) sbq.push_back('{120, 8, 1'b0});
            step();
            chk($sformatf("b15.ovld%0d", k), 32'(out_valid), 32'(k == 8));
            chk($sformatf("w6.ovf%0d", k), 32'(ovf6), 32'(k >= 5));
        end
        chk("b15.irdy", 32'(in_ready), 32'd0);
        chk("w6.acc", 32'(acc_out6), 32'(exp6));
        chk("w6.cnt", 32'(count6), 32'd8);
        wait_result("b15");

        in_valid = 1'b1; sum_in = 4'd7; out_ready = 1'b0;
        repeat (5) begin
            step();
            chk("hold.acc", 32'(acc_out), 32'd120);
            chk("hold.cnt", 32'(count), 32'd8);
            chk("hold.ovf", 32'(ovf), 32'd0);
            chk("hold.ovld", 32'(out_valid), 32'd1);
            chk("hold.w6acc", 32'(acc_out6), 32'(exp6));
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("drain.acc", 32'(acc_out), 32'd0);
        chk("drain.cnt", 32'(count), 32'd0);
        chk("drain.ovld", 32'(out_valid), 32'd0);
        chk("drain.irdy", 32'(in_ready), 32'd1);
        chk("drain.w6ovf", 32'(ovf6), 32'd0);

        random_batch("rnd0");
        random_batch("rnd1");

        in_valid1 = 1'b1; sum_in1 = 4'd9;
        step();
        chk("n1.ovld", 32'(out_valid1), 32'd1);
        chk("n1.acc", 32'(acc_out1), 32'd9);
        chk("n1.cnt", 32'(count1), 32'd1);
        chk("n1.irdy", 32'(in_ready1), 32'd0);
        out_ready1 = 1'b1; sum_in1 = 4'd4;
        step();
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        chk("n1.drain_ovld", 32'(out_valid1), 32'd0);
        chk("n1.drain_acc", 32'(acc_out1), 32'd0);
        chk("n1.drain_cnt", 32'(count1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
